// File: rtl/multicycle_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl_pkg
//   Shared definitions for the multicycle MIPS-subset controller:
//   opcode/funct constants, datapath select encodings, FSM state encoding,
//   the one-hot instruction-class struct and the bundled static-select struct.
//   No ports (package).
// ---------------------------------------------------------------------------
package multicycle_ctrl_pkg;

    // Opcode field instr[31:26]
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    // Funct field instr[5:0] for R-type
    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUBU  = 6'b100011;
    localparam logic [5:0] FN_JR    = 6'b001000;

    typedef enum logic [1:0] {
        NPC_PC4 = 2'b00,
        NPC_BEQ = 2'b01,
        NPC_J   = 2'b10,
        NPC_JR  = 2'b11
    } npc_op_e;

    typedef enum logic [1:0] {
        EXT_ZERO = 2'b00,
        EXT_SIGN = 2'b01,
        EXT_LUI  = 2'b10
    } ext_op_e;

    typedef enum logic [3:0] {
        ALU_ADD = 4'b0000,
        ALU_SUB = 4'b0001,
        ALU_OR  = 4'b0010
    } alu_op_e;

    typedef enum logic [1:0] {
        A3_RD = 2'b00,
        A3_RT = 2'b01,
        A3_RA = 2'b10
    } reg_a3_sel_e;

    typedef enum logic [1:0] {
        RD_ALU = 2'b00,
        RD_DM  = 2'b01,
        RD_EXT = 2'b10,
        RD_PC4 = 2'b11
    } reg_data_sel_e;

    typedef enum logic [1:0] {
        BSEL_RD2 = 2'b00,
        BSEL_EXT = 2'b01
    } alu_b_sel_e;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_e;

    // Exactly one flag is set for any IR value; unk covers everything else.
    typedef struct packed {
        logic addu;
        logic subu;
        logic ori;
        logic lui;
        logic lw;
        logic sw;
        logic beq;
        logic j;
        logic jal;
        logic jr;
        logic unk;
    } instr_class_t;

    // Selects that depend only on the instruction, held from DECODE onward.
    typedef struct packed {
        npc_op_e       npc_op;
        ext_op_e       ext_op;
        alu_op_e       alu_op;
        reg_a3_sel_e   a3_sel;
        reg_data_sel_e data_sel;
        alu_b_sel_e    b_sel;
    } ctrl_sel_t;

    localparam ctrl_sel_t SEL_IDLE = '{
        npc_op:   NPC_PC4,
        ext_op:   EXT_ZERO,
        alu_op:   ALU_ADD,
        a3_sel:   A3_RD,
        data_sel: RD_ALU,
        b_sel:    BSEL_RD2
    };

endpackage

// File: rtl/multicycle_ctrl_decode.sv
// ---------------------------------------------------------------------------
// mc_decode
//   Purely combinational instruction decoder. Classifies the IR opcode/funct
//   into a one-hot instruction class and produces the per-class static
//   datapath selects.
//   Ports:
//     op     in  6   IR opcode field
//     funct  in  6   IR funct field
//     cls    out     one-hot instruction class
//     sel    out     static selects for that class
// ---------------------------------------------------------------------------
module mc_decode
    import multicycle_ctrl_pkg::*;
(
    input  logic [5:0]   op,
    input  logic [5:0]   funct,
    output instr_class_t cls,
    output ctrl_sel_t    sel
);

    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves
        // it unassigned; an unassigned path would infer a latch.
        cls = '0;
        sel = SEL_IDLE;
        unique case (op)
            OP_RTYPE: begin
                unique case (funct)
                    FN_ADDU: begin
                        cls.addu   = 1'b1;
                        sel.alu_op = ALU_ADD;
                    end
                    FN_SUBU: begin
                        cls.subu   = 1'b1;
                        sel.alu_op = ALU_SUB;
                    end
                    FN_JR: begin
                        cls.jr     = 1'b1;
                        sel.npc_op = NPC_JR;
                    end
                    default: cls.unk = 1'b1;
                endcase
            end
            OP_ORI: begin
                cls.ori      = 1'b1;
                sel.ext_op   = EXT_ZERO;
                sel.b_sel    = BSEL_EXT;
                sel.alu_op   = ALU_OR;
                sel.a3_sel   = A3_RT;
                sel.data_sel = RD_ALU;
            end
            OP_LUI: begin
                cls.lui      = 1'b1;
                sel.ext_op   = EXT_LUI;
                sel.a3_sel   = A3_RT;
                sel.data_sel = RD_EXT;
            end
            OP_LW: begin
                cls.lw       = 1'b1;
                sel.ext_op   = EXT_SIGN;
                sel.b_sel    = BSEL_EXT;
                sel.alu_op   = ALU_ADD;
                sel.a3_sel   = A3_RT;
                sel.data_sel = RD_DM;
            end
            OP_SW: begin
                cls.sw     = 1'b1;
                sel.ext_op = EXT_SIGN;
                sel.b_sel  = BSEL_EXT;
                sel.alu_op = ALU_ADD;
            end
            OP_BEQ: begin
                // Compare via subtraction; the branch offset is sign-extended.
                cls.beq    = 1'b1;
                sel.alu_op = ALU_SUB;
                sel.ext_op = EXT_SIGN;
                sel.npc_op = NPC_BEQ;
            end
            OP_J: begin
                cls.j      = 1'b1;
                sel.npc_op = NPC_J;
            end
            OP_JAL: begin
                cls.jal      = 1'b1;
                sel.npc_op   = NPC_J;
                sel.a3_sel   = A3_RA;
                sel.data_sel = RD_PC4;
            end
            default: cls.unk = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl
//   Multicycle control FSM (FETCH/DECODE/EXEC/MEM/WB) driving the datapath
//   selects and write strobes. Outputs are Moore-style: a function of the
//   state and the latched IR only.
//   Ports:
//     clk, reset          clock; asynchronous active-high reset
//     instr      in  32   instruction word, sampled into IR during FETCH
//     Zero       in  1    ALU equality flag
//     IRWrite, PCWrite, RegWrite, MemWrite   write strobes
//     NPCOp, EXTOp, ALUOp, RegA3Sel, RegDataSel, AluBSel   datapath selects
//     retire     out 1    one-cycle pulse, identical to PCWrite
//     instr_cnt  out CNT_W retired-instruction count (wraps)
// ---------------------------------------------------------------------------
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      instr,
    input  logic             Zero,
    output logic             IRWrite,
    output logic             PCWrite,
    output logic [1:0]       NPCOp,
    output logic             RegWrite,
    output logic [1:0]       EXTOp,
    output logic [3:0]       ALUOp,
    output logic             MemWrite,
    output logic [1:0]       RegA3Sel,
    output logic [1:0]       RegDataSel,
    output logic [1:0]       AluBSel,
    output logic             retire,
    output logic [CNT_W-1:0] instr_cnt
);

    state_e           state_q, state_d;
    // The IR keeps only the fields the controller decodes.
    logic [5:0]       ir_op_q, ir_op_d;
    logic [5:0]       ir_fn_q, ir_fn_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    instr_class_t     cls;
    ctrl_sel_t        dec_sel;
    ctrl_sel_t        sel;
    logic             ir_wr, pc_wr, reg_wr, mem_wr;

    // beq resolution happens in the datapath's NPC unit (NPCOp=01 plus Zero),
    // so the controller itself never needs the flag.
    logic             zero_unused;
    assign zero_unused = Zero;

    mc_decode u_decode (
        .op    (ir_op_q),
        .funct (ir_fn_q),
        .cls   (cls),
        .sel   (dec_sel)
    );

    always_comb begin
        state_d = S_FETCH;
        sel     = SEL_IDLE;
        ir_wr   = 1'b0;
        pc_wr   = 1'b0;
        reg_wr  = 1'b0;
        mem_wr  = 1'b0;

        unique case (state_q)
            S_FETCH: begin
                ir_wr   = 1'b1;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                sel     = dec_sel;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                sel = dec_sel;
                if (cls.lw || cls.sw) begin
                    state_d = S_MEM;
                end else if (cls.addu || cls.subu || cls.ori || cls.lui) begin
                    state_d = S_WB;
                end else begin
                    // beq/j/jal/jr/unknown finish here.
                    pc_wr   = 1'b1;
                    reg_wr  = cls.jal;
                    state_d = S_FETCH;
                end
            end
            S_MEM: begin
                sel = dec_sel;
                if (cls.lw) begin
                    state_d = S_WB;
                end else begin
                    mem_wr  = cls.sw;
                    pc_wr   = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_WB: begin
                sel     = dec_sel;
                reg_wr  = 1'b1;
                pc_wr   = 1'b1;
                state_d = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase

        // Reset forces state to FETCH asynchronously, but FETCH raises
        // IRWrite, so strobes are explicitly suppressed while reset is high.
        if (reset) begin
            ir_wr  = 1'b0;
            pc_wr  = 1'b0;
            reg_wr = 1'b0;
            mem_wr = 1'b0;
        end

        ir_op_d = ir_wr ? instr[31:26] : ir_op_q;
        ir_fn_d = ir_wr ? instr[5:0]   : ir_fn_q;
        cnt_d   = pc_wr ? cnt_q + CNT_W'(1) : cnt_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
            ir_op_q <= '0;
            ir_fn_q <= '0;
            cnt_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // pre-edge values regardless of statement order.
            state_q <= state_d;
            ir_op_q <= ir_op_d;
            ir_fn_q <= ir_fn_d;
            cnt_q   <= cnt_d;
        end
    end

    assign IRWrite    = ir_wr;
    assign PCWrite    = pc_wr;
    assign RegWrite   = reg_wr;
    assign MemWrite   = mem_wr;
    assign retire     = pc_wr;
    assign NPCOp      = sel.npc_op;
    assign EXTOp      = sel.ext_op;
    assign ALUOp      = sel.alu_op;
    assign RegA3Sel   = sel.a3_sel;
    assign RegDataSel = sel.data_sel;
    assign AluBSel    = sel.b_sel;
    assign instr_cnt  = cnt_q;

endmodule
